// File: rtl/ap_ddr_pkg.sv
// ap_ddr_pkg
// Shared definitions for the DDR burst arbiter: the arbiter FSM state encoding,
// the default burst length, the width of the DDR burst-length field and the
// fixed requester slot indices used by the cache / AP_ctrl layer.
package ap_ddr_pkg;

  localparam int LEN_W             = 10;  // DDR burst-length field width
  localparam int BURST_LEN_DEFAULT = 16;  // beats per burst

  // Requester slot indices
  localparam int REQ_INSTR = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_CTXT  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ddr_burst_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational rotate-priority pick. The search starts at ptr and
// wraps modulo NUM_REQ; the first requesting index wins.
// Ports:
//   req    - per-requester pending vector
//   ptr    - index with highest priority this round
//   onehot - one-hot winner (all zero when nothing pending)
//   idx    - binary winner index (0 when nothing pending)
//   valid  - at least one requester pending
module rr_arbiter
  import ap_ddr_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid) begin
        cand = (int'(ptr) + i) % NUM_REQ;
        if (req[cand]) begin
          valid        = 1'b1;
          idx          = IDX_W'(cand);
          onehot[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Shares one DDR burst interface between the instruction cache, data cache and
// context store. One whole burst is granted at a time, round-robin; a requester
// with both a write-back and a refill pending is served write-back first.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_read / req_store        - per-requester level requests, held until req_done
//   req_read_addr/write_addr    - packed per-requester DDR addresses
//   req_wr_data                 - packed per-requester write beats
//   grant                       - one-hot current owner
//   req_rd_valid                - registered read-beat strobe, owner only
//   req_wr_data_req             - write-beat request pass-through, owner only
//   req_done                    - one-cycle burst-complete pulse
//   rd_data / rd_cnt            - registered read beat, beats delivered this burst
//   rd_burst_* / wr_burst_*     - DDR burst interface
module ddr_burst_arbiter
  import ap_ddr_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BURST_LEN      = BURST_LEN_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_read,
  input  logic [NUM_REQ-1:0]                  req_store,
  input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]   req_read_addr,
  input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]   req_write_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wr_data,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  req_rd_valid,
  output logic [NUM_REQ-1:0]                  req_wr_data_req,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [LEN_W-1:0]                    rd_cnt,
  output logic                                rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]           rd_burst_addr,
  output logic [LEN_W-1:0]                    rd_burst_len,
  input  logic                                rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]               rd_burst_data,
  input  logic                                rd_burst_finish,
  output logic                                wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]           wr_burst_addr,
  output logic [LEN_W-1:0]                    wr_burst_len,
  input  logic                                wr_burst_data_req,
  output logic [DATA_WIDTH-1:0]               wr_burst_data,
  input  logic                                wr_burst_finish
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]        rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0]        req_done_q, req_done_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [LEN_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic                      rd_burst_req_q, rd_burst_req_d;
  logic                      wr_burst_req_q, wr_burst_req_d;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr_q, rd_burst_addr_d;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr_q, wr_burst_addr_d;

  logic [NUM_REQ-1:0]        pick_onehot;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (req_read | req_store),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    grant_d         = grant_q;
    rd_valid_d      = '0;
    req_done_d      = '0;
    rd_data_d       = rd_data_q;
    rd_cnt_d        = rd_cnt_q;
    rd_burst_req_d  = rd_burst_req_q;
    wr_burst_req_d  = wr_burst_req_q;
    rd_burst_addr_d = rd_burst_addr_q;
    wr_burst_addr_d = wr_burst_addr_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_onehot;
          owner_d  = pick_idx;
          rd_cnt_d = '0;
          // Write-back goes before refill so a dirty line is never lost.
          if (req_store[pick_idx]) begin
            wr_burst_req_d  = 1'b1;
            wr_burst_addr_d = req_write_addr[int'(pick_idx)*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
            state_d         = WR_BURST;
          end else begin
            rd_burst_req_d  = 1'b1;
            rd_burst_addr_d = req_read_addr[int'(pick_idx)*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
            state_d         = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        // Beats past the burst length are dropped; rd_cnt saturates.
        if (rd_burst_data_valid && (rd_cnt_q < LEN_W'(BURST_LEN))) begin
          rd_data_d  = rd_burst_data;
          rd_valid_d = grant_q;
          rd_cnt_d   = rd_cnt_q + 1'b1;
        end
        if (rd_burst_finish) begin
          state_d        = DONE;
          rd_burst_req_d = 1'b0;
          req_done_d     = grant_q;
          grant_d        = '0;
          rr_ptr_d       = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        end
      end
      WR_BURST: begin
        if (wr_burst_finish) begin
          state_d        = DONE;
          wr_burst_req_d = 1'b0;
          req_done_d     = grant_q;
          grant_d        = '0;
          rr_ptr_d       = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      grant_q         <= '0;
      rd_valid_q      <= '0;
      req_done_q      <= '0;
      rd_data_q       <= '0;
      rd_cnt_q        <= '0;
      rd_burst_req_q  <= 1'b0;
      wr_burst_req_q  <= 1'b0;
      rd_burst_addr_q <= '0;
      wr_burst_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      grant_q         <= grant_d;
      rd_valid_q      <= rd_valid_d;
      req_done_q      <= req_done_d;
      rd_data_q       <= rd_data_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_burst_req_q  <= rd_burst_req_d;
      wr_burst_req_q  <= wr_burst_req_d;
      rd_burst_addr_q <= rd_burst_addr_d;
      wr_burst_addr_q <= wr_burst_addr_d;
    end
  end

  // Write-side steering is combinational so the DDR side sees the owner's
  // beat in the same cycle it asks for it.
  always_comb begin
    wr_burst_data = '0;
    if (grant_q != '0) begin
      wr_burst_data = req_wr_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_wr_data_req = (state_q == WR_BURST) ? (grant_q & {NUM_REQ{wr_burst_data_req}}) : '0;

  assign grant         = grant_q;
  assign req_rd_valid  = rd_valid_q;
  assign req_done      = req_done_q;
  assign rd_data       = rd_data_q;
  assign rd_cnt        = rd_cnt_q;
  assign rd_burst_req  = rd_burst_req_q;
  assign rd_burst_addr = rd_burst_addr_q;
  assign wr_burst_req  = wr_burst_req_q;
  assign wr_burst_addr = wr_burst_addr_q;
  assign rd_burst_len  = LEN_W'(BURST_LEN);
  assign wr_burst_len  = LEN_W'(BURST_LEN);

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter
// Self-checking bench for ddr_burst_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. Read beats and write
// beats are pushed to scoreboard queues as they are driven and popped when the
// arbiter presents them to the requester side.
module tb_ddr_burst_arbiter;
  import ap_ddr_pkg::*;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 28;
  localparam int BL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_read, req_store;
  logic [N*AW-1:0] req_read_addr, req_write_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]    grant, req_rd_valid, req_wr_data_req, req_done;
  logic [DW-1:0]   rd_data;
  logic [9:0]      rd_cnt, rd_burst_len, wr_burst_len;
  logic            rd_burst_req, wr_burst_req;
  logic [AW-1:0]   rd_burst_addr, wr_burst_addr;
  logic            rd_burst_data_valid, rd_burst_finish;
  logic [DW-1:0]   rd_burst_data;
  logic            wr_burst_data_req, wr_burst_finish;
  logic [DW-1:0]   wr_burst_data;

  typedef struct packed {
    logic [N-1:0]  vec;
    logic [DW-1:0] data;
  } beat_t;

  beat_t rd_q[$];
  beat_t wr_q[$];
  beat_t mon_e;
  int    n_cmp = 0;
  int    n_err = 0;

  ddr_burst_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_read            (req_read),
    .req_store           (req_store),
    .req_read_addr       (req_read_addr),
    .req_write_addr      (req_write_addr),
    .req_wr_data         (req_wr_data),
    .grant               (grant),
    .req_rd_valid        (req_rd_valid),
    .req_wr_data_req     (req_wr_data_req),
    .req_done            (req_done),
    .rd_data             (rd_data),
    .rd_cnt              (rd_cnt),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read-beat monitor: every strobe must match the oldest driven in-range beat.
  always @(negedge clk) begin
    if (!rst && req_rd_valid != '0) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: req_rd_valid=%b rd_data=%h, no beat outstanding", req_rd_valid, rd_data);
      end else begin
        mon_e = rd_q.pop_front();
        if (req_rd_valid !== mon_e.vec || rd_data !== mon_e.data) begin
          n_err++;
          $display("FAIL rd_beat: got vec=%b data=%h, expected vec=%b data=%h",
                   req_rd_valid, rd_data, mon_e.vec, mon_e.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, then checks owner, burst type and address.
  task automatic wait_grant(input logic [N-1:0] exp, input bit is_wr,
                            input logic [AW-1:0] addr, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (grant !== '0) seen = 1'b1;
      else cycle();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_grant_timeout: no grant within 20 cycles, expected %b", name, exp);
    end else begin
      if (grant !== exp) begin
        n_err++;
        $display("FAIL %s_grant: got %b expected %b", name, grant, exp);
      end
      n_cmp++;
      if (is_wr ? (wr_burst_req !== 1'b1 || rd_burst_req !== 1'b0 || wr_burst_addr !== addr)
                : (rd_burst_req !== 1'b1 || wr_burst_req !== 1'b0 || rd_burst_addr !== addr)) begin
        n_err++;
        $display("FAIL %s_burst: got rd_req=%b wr_req=%b rd_addr=%h wr_addr=%h, expected %s req addr=%h",
                 name, rd_burst_req, wr_burst_req, rd_burst_addr, wr_burst_addr,
                 is_wr ? "wr" : "rd", addr);
      end
      cycle();
    end
  endtask

  task automatic rd_beats(input logic [N-1:0] vec, input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = base + DW'(k);
      if (k < BL) rd_q.push_back('{vec: vec, data: base + DW'(k)});
      cycle();
    end
    rd_burst_data_valid = 1'b0;
  endtask

  // Pulses the finish strobe, then checks the one-cycle DONE pulse.
  task automatic finish_burst(input bit is_rd, input logic [N-1:0] owner,
                              input logic [N-1:0] new_read, input logic [N-1:0] new_store,
                              input string name);
    if (is_rd) rd_burst_finish = 1'b1;
    else       wr_burst_finish = 1'b1;
    cycle();
    rd_burst_finish     = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;
    req_read            = new_read;
    req_store           = new_store;
    @(negedge clk);
    n_cmp++;
    if (req_done !== owner || grant !== '0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done: got done=%b grant=%b rd_req=%b wr_req=%b, expected done=%b grant=0 reqs=0",
               name, req_done, grant, rd_burst_req, wr_burst_req, owner);
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (req_done !== '0) begin
      n_err++;
      $display("FAIL %s_done_width: got done=%b expected 000", name, req_done);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    @(negedge clk);
    n_cmp++;
    if (grant !== '0 || req_done !== '0 || req_rd_valid !== '0 || req_wr_data_req !== '0 ||
        rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0 || rd_cnt !== '0 || rd_data !== '0 ||
        rd_burst_addr !== '0 || wr_burst_addr !== '0 || wr_burst_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: grant=%b done=%b rd_req=%b wr_req=%b rd_cnt=%0d wr_data=%h, expected all 0",
               grant, req_done, rd_burst_req, wr_burst_req, rd_cnt, wr_burst_data);
    end
    n_cmp++;
    if (rd_burst_len !== 10'd16 || wr_burst_len !== 10'd16) begin
      n_err++;
      $display("FAIL reset_len: got rd_len=%0d wr_len=%0d expected 16", rd_burst_len, wr_burst_len);
    end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_read();
    req_read_addr[REQ_DATA*AW +: AW] = 28'h00000A0;
    req_read = 3'b010;
    @(negedge clk);
    n_cmp++;
    if (grant !== '0) begin
      n_err++;
      $display("FAIL single_early_grant: got %b expected 000 before the edge", grant);
    end
    cycle();
    wait_grant(3'b010, 1'b0, 28'h00000A0, "single");
    // First beat: the strobe must not appear in the same cycle it is driven.
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = 16'h1000;
    rd_q.push_back('{vec: 3'b010, data: 16'h1000});
    @(negedge clk);
    n_cmp++;
    if (req_rd_valid !== '0 || rd_cnt !== 10'd0) begin
      n_err++;
      $display("FAIL single_latency: got rd_valid=%b rd_cnt=%0d expected 000 and 0", req_rd_valid, rd_cnt);
    end
    cycle();
    rd_beats(3'b010, 16'h1001, 14);
    // Sixteenth beat arrives together with the finish strobe.
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = 16'h100F;
    rd_q.push_back('{vec: 3'b010, data: 16'h100F});
    finish_burst(1'b1, 3'b010, 3'b000, 3'b000, "single");
    @(negedge clk);
    n_cmp++;
    if (rd_cnt !== 10'd16 || grant !== '0) begin
      n_err++;
      $display("FAIL single_rd_cnt: got rd_cnt=%0d grant=%b expected 16 and 000", rd_cnt, grant);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [4];
    logic [N-1:0] keep;
    int           idx;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    for (int i = 0; i < N; i++) req_read_addr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
    rst      = 1'b1;
    req_read = 3'b111;
    cycle();
    cycle();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      idx  = (order[g] == 3'b001) ? 0 : (order[g] == 3'b010) ? 1 : 2;
      keep = (g == 3) ? 3'b000 : 3'b111;
      wait_grant(order[g], 1'b0, AW'(32'h1000 * (idx + 1)), "rr");
      rd_beats(order[g], DW'(16'h2000 + 16 * g), 2);
      finish_burst(1'b1, order[g], keep, 3'b000, "rr");
    end
  endtask

  task automatic test_store_before_read();
    beat_t e;
    req_write_addr[REQ_DATA*AW +: AW] = 28'h0000040;
    req_read_addr[REQ_DATA*AW +: AW]  = 28'h0000080;
    req_wr_data[REQ_INSTR*DW +: DW]   = 16'h1111;
    req_wr_data[REQ_CTXT*DW +: DW]    = 16'h2222;
    req_store = 3'b010;
    req_read  = 3'b010;
    wait_grant(3'b010, 1'b1, 28'h0000040, "sbr_wr");
    for (int k = 0; k < 4; k++) begin
      wr_burst_data_req            = (k != 2);
      req_wr_data[REQ_DATA*DW +: DW] = 16'hBEE0 + DW'(k);
      if (k != 2) wr_q.push_back('{vec: 3'b010, data: 16'hBEE0 + DW'(k)});
      @(negedge clk);
      n_cmp++;
      if (k != 2) begin
        e = wr_q.pop_front();
        if (req_wr_data_req !== e.vec || wr_burst_data !== e.data) begin
          n_err++;
          $display("FAIL sbr_wr_beat: got req=%b data=%h expected req=%b data=%h",
                   req_wr_data_req, wr_burst_data, e.vec, e.data);
        end
      end else if (req_wr_data_req !== '0) begin
        n_err++;
        $display("FAIL sbr_wr_idle: got req=%b expected 000", req_wr_data_req);
      end
      cycle();
    end
    wr_burst_data_req = 1'b0;
    finish_burst(1'b0, 3'b010, 3'b010, 3'b000, "sbr_wr");
    wait_grant(3'b010, 1'b0, 28'h0000080, "sbr_rd");
    rd_beats(3'b010, 16'h3000, 2);
    finish_burst(1'b1, 3'b010, 3'b000, 3'b000, "sbr_rd");
  endtask

  task automatic test_isolation();
    req_read_addr[REQ_INSTR*AW +: AW] = 28'h0000100;
    req_wr_data[REQ_INSTR*DW +: DW]   = 16'h5A5A;
    req_wr_data[REQ_DATA*DW +: DW]    = 16'h3333;
    req_wr_data[REQ_CTXT*DW +: DW]    = 16'h7777;
    req_read = 3'b001;
    wait_grant(3'b001, 1'b0, 28'h0000100, "iso");
    @(negedge clk);
    n_cmp++;
    if (wr_burst_data !== 16'h5A5A) begin
      n_err++;
      $display("FAIL iso_wr_mux: got %h expected 5a5a", wr_burst_data);
    end
    cycle();
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = 16'hC0DE;
    wr_burst_finish     = 1'b1;
    rd_q.push_back('{vec: 3'b001, data: 16'hC0DE});
    cycle();
    rd_burst_data_valid = 1'b0;
    wr_burst_finish     = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_rd_valid[2:1] !== 2'b00 || grant !== 3'b001 || rd_burst_req !== 1'b1 || req_done !== '0) begin
      n_err++;
      $display("FAIL iso_stray_finish: got rd_valid=%b grant=%b rd_req=%b done=%b expected x00/001/1/000",
               req_rd_valid, grant, rd_burst_req, req_done);
    end
    cycle();
    finish_burst(1'b1, 3'b001, 3'b000, 3'b000, "iso");
  endtask

  task automatic test_reset_mid_burst();
    req_write_addr[REQ_CTXT*AW +: AW] = 28'h0000200;
    req_store = 3'b100;
    wait_grant(3'b100, 1'b1, 28'h0000200, "rstmid");
    for (int k = 0; k < 5; k++) begin
      wr_burst_data_req = 1'b1;
      if (k == 4) rst = 1'b1;
      cycle();
    end
    wr_burst_data_req = 1'b0;
    req_store         = 3'b000;
    @(negedge clk);
    n_cmp++;
    if (grant !== '0 || req_done !== '0 || wr_burst_req !== 1'b0 || rd_burst_req !== 1'b0 ||
        wr_burst_addr !== '0 || wr_burst_data !== '0 || req_wr_data_req !== '0 ||
        rd_cnt !== '0 || rd_burst_len !== 10'd16) begin
      n_err++;
      $display("FAIL rstmid_outputs: grant=%b done=%b wr_req=%b wr_addr=%h wr_data=%h rd_cnt=%0d len=%0d",
               grant, req_done, wr_burst_req, wr_burst_addr, wr_burst_data, rd_cnt, rd_burst_len);
    end
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_done !== '0 || grant !== '0) begin
        n_err++;
        $display("FAIL rstmid_no_done: got done=%b grant=%b expected 000/000", req_done, grant);
      end
      cycle();
    end
    // rr_ptr must be back at 0: requesters 0 and 2 pending -> 0 wins.
    req_read_addr[REQ_INSTR*AW +: AW] = 28'h0000500;
    req_read_addr[REQ_CTXT*AW +: AW]  = 28'h0000600;
    req_read = 3'b101;
    wait_grant(3'b001, 1'b0, 28'h0000500, "rstmid_fresh");
    rd_beats(3'b001, 16'h4000, 1);
    finish_burst(1'b1, 3'b001, 3'b000, 3'b000, "rstmid_fresh");
  endtask

  task automatic test_extra_beats();
    req_read_addr[REQ_DATA*AW +: AW] = 28'h0000300;
    req_read = 3'b010;
    wait_grant(3'b010, 1'b0, 28'h0000300, "extra");
    rd_beats(3'b010, 16'h5000, 18);
    @(negedge clk);
    n_cmp++;
    if (rd_cnt !== 10'd16) begin
      n_err++;
      $display("FAIL extra_saturate: got rd_cnt=%0d expected 16", rd_cnt);
    end
    cycle();
    finish_burst(1'b1, 3'b010, 3'b000, 3'b000, "extra");
  endtask

  initial begin
    rst                 = 1'b1;
    req_read            = '0;
    req_store           = '0;
    req_read_addr       = '0;
    req_write_addr      = '0;
    req_wr_data         = '0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = '0;
    rd_burst_finish     = 1'b0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    #1;

    test_reset();
    test_single_read();
    test_round_robin();
    test_store_before_read();
    test_isolation();
    test_reset_mid_burst();
    test_extra_beats();

    cycle();
    n_cmp++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d read and %0d write beats never delivered", rd_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
- Shares the single DDR burst interface between the instruction cache, data cache and context-store requesters.
- Grants one whole burst at a time with round-robin fairness and drives the burst request, address and length.
- Steers read beats and write-data requests back to the granted requester only.
- Sits between the cache/AP_ctrl layer and the DDR interface module.

Parameters:
- NUM_REQ, 3, number of requesters (0 = instruction cache, 1 = data cache, 2 = context store).
- DATA_WIDTH, 16, DDR beat width.
- DDR_ADDR_WIDTH, 28, DDR byte address width.
- BURST_LEN, 16, beats per burst (10-bit length field).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read (refill) request; level, held until done.
- req_store  in  NUM_REQ  per-requester store (write-back) request; level, held until done.
- req_read_addr  in  NUM_REQ*DDR_ADDR_WIDTH  packed read addresses; slot i = bits [i*W +: W].
- req_write_addr  in  NUM_REQ*DDR_ADDR_WIDTH  packed write addresses.
- req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write beats.
- grant  out  NUM_REQ  one-hot current owner.
- req_rd_valid  out  NUM_REQ  read beat valid, owner only.
- req_wr_data_req  out  NUM_REQ  write beat request, owner only.
- req_done  out  NUM_REQ  one-cycle burst-complete pulse.
- rd_data  out  DATA_WIDTH  read beat to requesters, registered.
- rd_cnt  out  10  beats delivered in the current read burst.
- rd_burst_req  out  1  DDR read burst request.
- rd_burst_addr  out  DDR_ADDR_WIDTH  latched read address.
- rd_burst_len  out  10  equals BURST_LEN.
- rd_burst_data_valid  in  1  DDR read beat valid.
- rd_burst_data  in  DATA_WIDTH  DDR read beat.
- rd_burst_finish  in  1  DDR read burst complete.
- wr_burst_req  out  1  DDR write burst request.
- wr_burst_addr  out  DDR_ADDR_WIDTH  latched write address.
- wr_burst_len  out  10  equals BURST_LEN.
- wr_burst_data_req  in  1  DDR requests next write beat.
- wr_burst_data  out  DATA_WIDTH  owner's write beat, combinational mux.
- wr_burst_finish  in  1  DDR write burst complete.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, rr_ptr=0. All outputs 0 except rd_burst_len and wr_burst_len, which are constant BURST_LEN. A burst in flight is abandoned; no req_done is issued for it.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE arbitration:
  - Requester i is pending when req_read[i] or req_store[i] is high.
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first pending index wins.
  - If the winner has both requests high, store goes first: write-back before refill.
  - On the next edge: grant=onehot(winner); the winner's address is latched; rd_burst_req or wr_burst_req rises; state moves to RD_BURST or WR_BURST.
  - Latency: request seen at edge n, burst req high after edge n+1.
- RD_BURST:
  - rd_burst_req stays high until rd_burst_finish.
  - Each rd_burst_data_valid beat: rd_data registered, req_rd_valid[owner] pulses one cycle later, rd_cnt increments; rd_cnt resets to 0 at grant.
  - Beats beyond BURST_LEN are dropped and rd_cnt saturates.
  - rd_burst_finish moves the FSM to DONE.
- WR_BURST:
  - wr_burst_req stays high until wr_burst_finish.
  - req_wr_data_req[owner] = wr_burst_data_req, combinational pass-through.
  - wr_burst_data = owner's req_wr_data slice when grant is valid, else 0.
  - wr_burst_finish moves the FSM to DONE.
- DONE (one cycle):
  - req_done[owner]=1, burst reqs low, grant cleared, rr_ptr=(owner+1) mod NUM_REQ; then IDLE.
  - A requester with a store then a read pending completes the store, then re-arbitrates fairly for the read.
- Request rules:
  - Requesters must hold req until req_done.
  - Deasserting req mid-burst is ignored; the burst completes.
  - Req still high in the cycle after req_done is treated as a new request.
- A finish pulse of the wrong type (wr finish during RD_BURST, or either finish in IDLE) is ignored.
- Simultaneous rd_burst_data_valid and finish in the same cycle: the beat is captured, then DONE.
- No request is granted while not IDLE, so bursts never overlap.

Decomposition:
- Shared package ap_ddr_pkg: state encodings, BURST_LEN default, requester index constants (REQ_INSTR=0, REQ_DATA=1, REQ_CTXT=2), burst length width 10.
- One sub-module: rr_arbiter (combinational rotate-priority pick over NUM_REQ given rr_ptr; returns one-hot and index).

Test Plan:
- Single read: req_read=3'b010, addr 0x0000A0 -> grant=010 one cycle later, rd_burst_addr=0xA0; 16 beats 0x1000..0x100F appear on rd_data with req_rd_valid[1]; rd_cnt reaches 16; req_done[1] one pulse after finish.
- Round-robin: all three req_read held from reset -> grant order 001,010,100,001; each burst completes before the next grant.
- Store-before-read: req_store[1] and req_read[1] together, write addr 0x40, read addr 0x80 -> WR burst to 0x40 first; data slice forwarded on each wr_burst_data_req; then read to 0x80 after re-arbitration.
- Isolation: during an owner-0 read, req_rd_valid[2:1]=0 and wr_burst_data=owner slice; stray wr_burst_finish in RD_BURST -> no state change.
- Reset mid-burst: rst=1 at beat 5 of a write -> next cycle all outputs 0, grant=0, no req_done; a fresh request after reset is granted normally with rr_ptr=0.
- Extra beats: 18 rd_burst_data_valid beats before finish -> rd_cnt saturates at 16; beats 17–18 not signalled.
